// File: rtl/vga_superpix_renderer.sv
// VGA raster engine: pixel-enable divider, H/V timing, superpixel addressing and
// a three-stage pipeline driving registered RGB and sync pins in four render modes.
module vga_superpix_renderer #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter int   CLK_DIV  = 2,
    parameter int   SP_SHIFT = 5,
    parameter int   COLOR_W  = 1,
    parameter int   ADDR_W   = 9,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           mode,
    input  logic [3*COLOR_W-1:0] fg_color,
    input  logic [3*COLOR_W-1:0] bg_color,
    output logic [ADDR_W-1:0]    mem_addr,
    input  logic [3*COLOR_W-1:0] mem_data,
    output logic [COLOR_W-1:0]   R,
    output logic [COLOR_W-1:0]   G,
    output logic [COLOR_W-1:0]   B,
    output logic                 hSync,
    output logic                 vSync,
    output logic                 frame_start
);

    localparam int H_TOT   = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT   = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOT + 1);
    localparam int VW      = $clog2(V_TOT + 1);
    localparam int DW      = $clog2(CLK_DIV);
    localparam int CW      = 3 * COLOR_W;
    localparam int SP_COLS = (H_ACTIVE + (1 << SP_SHIFT) - 1) >> SP_SHIFT;
    localparam int SP_ROWS = (V_ACTIVE + (1 << SP_SHIFT) - 1) >> SP_SHIFT;

    localparam logic [DW-1:0]     DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [HW-1:0]     H_LAST    = HW'(H_TOT - 1);
    localparam logic [HW-1:0]     H_ACT_L   = HW'(H_ACTIVE);
    localparam logic [HW-1:0]     HS_START  = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0]     HS_END    = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0]     V_LAST    = VW'(V_TOT - 1);
    localparam logic [VW-1:0]     V_ACT_L   = VW'(V_ACTIVE);
    localparam logic [VW-1:0]     VS_START  = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0]     VS_END    = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [HW-1:0]     LAST_COL  = HW'(SP_COLS - 1);
    localparam logic [VW-1:0]     LAST_ROW  = VW'(SP_ROWS - 1);
    localparam logic [ADDR_W-1:0] SP_COLS_A = ADDR_W'(SP_COLS);

    typedef enum logic [1:0] {
        MODE_SOLID    = 2'd0,
        MODE_CHECKER  = 2'd1,
        MODE_FRAMEBUF = 2'd2,
        MODE_BORDER   = 2'd3
    } mode_t;

    logic [DW-1:0] div_reg;
    logic          pix_en;

    logic [HW-1:0] h_cnt_reg;
    logic [VW-1:0] v_cnt_reg;
    logic          h_last;
    logic          v_last;

    logic              a_active, a_hs, a_vs, a_first;
    logic [HW-1:0]     a_xsp;
    logic [VW-1:0]     a_ysp;
    logic [ADDR_W-1:0] addr_next;

    logic          b_active_reg, b_hs_reg, b_vs_reg, b_first_reg;
    logic [HW-1:0] b_xsp_reg;
    logic [VW-1:0] b_ysp_reg;
    mode_t         mode_q_reg;

    logic [CW-1:0]      colour_next;
    logic [CW-1:0]      rgb_reg;
    logic [COLOR_W-1:0] chan [3];

    assign pix_en = (div_reg == DIV_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            div_reg <= '0;
        end else if (pix_en) begin
            div_reg <= '0;
        end else begin
            div_reg <= div_reg + DW'(1);
        end
    end

    // Stage A: raster counters
    assign h_last = (h_cnt_reg == H_LAST);
    assign v_last = (v_cnt_reg == V_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt_reg <= '0;
            v_cnt_reg <= '0;
        end else if (pix_en) begin
            if (h_last) begin
                h_cnt_reg <= '0;
                v_cnt_reg <= v_last ? '0 : v_cnt_reg + VW'(1);
            end else begin
                h_cnt_reg <= h_cnt_reg + HW'(1);
            end
        end
    end

    always_comb begin
        a_active  = (h_cnt_reg < H_ACT_L) && (v_cnt_reg < V_ACT_L);
        a_hs      = (h_cnt_reg >= HS_START) && (h_cnt_reg < HS_END);
        a_vs      = (v_cnt_reg >= VS_START) && (v_cnt_reg < VS_END);
        a_first   = (h_cnt_reg == '0) && (v_cnt_reg == '0);
        a_xsp     = h_cnt_reg >> SP_SHIFT;
        a_ysp     = v_cnt_reg >> SP_SHIFT;
        // Computed modulo 2^ADDR_W, which equals truncating the full product.
        addr_next = ADDR_W'(a_ysp) * SP_COLS_A + ADDR_W'(a_xsp);
    end

    // Stage B: superpixel coordinates, framebuffer address and delayed flags
    always_ff @(posedge clk) begin
        if (reset) begin
            b_active_reg <= 1'b0;
            b_hs_reg     <= 1'b0;
            b_vs_reg     <= 1'b0;
            b_first_reg  <= 1'b0;
            b_xsp_reg    <= '0;
            b_ysp_reg    <= '0;
            mem_addr     <= '0;
            mode_q_reg   <= MODE_SOLID;
        end else if (pix_en) begin
            b_active_reg <= a_active;
            b_hs_reg     <= a_hs;
            b_vs_reg     <= a_vs;
            b_first_reg  <= a_first;
            b_xsp_reg    <= a_xsp;
            b_ysp_reg    <= a_ysp;
            if (a_active) begin
                mem_addr <= addr_next;
            end
            // Only sampled at the frame origin so a frame never mixes two modes.
            if (a_first) begin
                mode_q_reg <= mode_t'(mode);
            end
        end
    end

    // Stage C: colour selection
    always_comb begin
        colour_next = '0;
        if (b_active_reg) begin
            case (mode_q_reg)
                MODE_SOLID:    colour_next = fg_color;
                MODE_CHECKER:  colour_next = (b_xsp_reg[0] ^ b_ysp_reg[0]) ? fg_color : bg_color;
                MODE_FRAMEBUF: colour_next = mem_data;
                MODE_BORDER:   colour_next = ((b_xsp_reg == '0) || (b_ysp_reg == '0) ||
                                              (b_xsp_reg == LAST_COL) || (b_ysp_reg == LAST_ROW))
                                             ? fg_color : bg_color;
                default:       colour_next = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rgb_reg     <= '0;
            hSync       <= ~SYNC_POL;
            vSync       <= ~SYNC_POL;
            frame_start <= 1'b0;
        end else begin
            frame_start <= pix_en && b_first_reg;
            if (pix_en) begin
                rgb_reg <= colour_next;
                hSync   <= b_hs_reg ? SYNC_POL : ~SYNC_POL;
                vSync   <= b_vs_reg ? SYNC_POL : ~SYNC_POL;
            end
        end
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g_chan
        assign chan[gi] = rgb_reg[gi*COLOR_W +: COLOR_W];
    end

    assign R = chan[2];
    assign G = chan[1];
    assign B = chan[0];

endmodule

// File: tb/tb_vga_superpix_renderer.sv
// Directed bench for vga_superpix_renderer on a shrunken raster (44x24 total,
// 36x20 visible, 8-pixel superpixels giving 5x3 with a partial last column/row).
module tb_vga_superpix_renderer;

    localparam int H_TOT     = 44;
    localparam int FRAME_CLK = 2112;   // 44 * 24 pixels * 2 clk

    logic       clk;
    logic       reset;
    logic [1:0] mode;
    logic [2:0] fg_color, bg_color;
    logic [4:0] mem_addr;
    logic [2:0] mem_data;
    logic       R, G, B, hSync, vSync, frame_start;
    logic [2:0] rgb;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int fs_cyc = 0;
    int fs_prev = 0;

    vga_superpix_renderer #(
        .H_ACTIVE(36), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_ACTIVE(20), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .CLK_DIV(2), .SP_SHIFT(3), .COLOR_W(1), .ADDR_W(5), .SYNC_POL(1'b0)
    ) dut (
        .clk(clk), .reset(reset), .mode(mode),
        .fg_color(fg_color), .bg_color(bg_color),
        .mem_addr(mem_addr), .mem_data(mem_data),
        .R(R), .G(G), .B(B), .hSync(hSync), .vSync(vSync),
        .frame_start(frame_start)
    );

    assign rgb = {R, G, B};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Framebuffer model: registered read, each word holds the low address bits.
    always @(posedge clk) mem_data <= mem_addr[2:0];

    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        if (frame_start) begin
            fs_prev = fs_cyc;
            fs_cyc  = cyc;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Wait until output pixel (h,v) of the current or a later frame is on the pins.
    task automatic at_pixel(input int h, input int v);
        int target;
        target = fs_cyc + 2 * (v * H_TOT + h);
        while (target < cyc) target += FRAME_CLK;
        while (cyc != target) @(negedge clk);
    endtask

    task automatic chk_rgb(input string tag, input int h, input int v, input logic [2:0] exp);
        at_pixel(h, v);
        check_eq(tag, {29'd0, rgb}, {29'd0, exp});
    endtask

    initial begin
        #700000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int fs_n;
        logic vs_ok;

        reset    = 1'b1;
        mode     = 2'd0;
        fg_color = 3'b101;
        bg_color = 3'b010;
        repeat (3) @(negedge clk);
        check_eq("rst_rgb",   {29'd0, rgb}, 32'd0);
        check_eq("rst_hsync", {31'd0, hSync}, 32'd1);
        check_eq("rst_vsync", {31'd0, vSync}, 32'd1);
        check_eq("rst_addr",  {27'd0, mem_addr}, 32'd0);
        check_eq("rst_fs",    {31'd0, frame_start}, 32'd0);

        reset = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_start && n < 100);
        check_eq("first_fs_clk", n, 32'd4);

        // Solid mode, syncs and blanking
        chk_rgb("m0_px_0_0", 0, 0, 3'b101);
        chk_rgb("m0_hblank", 36, 0, 3'b000);
        at_pixel(37, 0); check_eq("hs_before", {31'd0, hSync}, 32'd1);
        at_pixel(38, 0); check_eq("hs_first",  {31'd0, hSync}, 32'd0);
        at_pixel(41, 0); check_eq("hs_last",   {31'd0, hSync}, 32'd0);
        at_pixel(42, 0); check_eq("hs_after",  {31'd0, hSync}, 32'd1);
        chk_rgb("m0_px_35_19", 35, 19, 3'b101);
        chk_rgb("m0_vblank", 10, 20, 3'b000);
        check_eq("vs_before", {31'd0, vSync}, 32'd1);
        at_pixel(0, 21);  check_eq("vs_first", {31'd0, vSync}, 32'd0);
        at_pixel(43, 22); check_eq("vs_last",  {31'd0, vSync}, 32'd0);
        at_pixel(0, 23);  check_eq("vs_after", {31'd0, vSync}, 32'd1);
        at_pixel(0, 0);
        check_eq("frame_period", fs_cyc - fs_prev, FRAME_CLK);

        // Mode change mid-frame only lands at the next frame origin
        chk_rgb("sw_before", 0, 10, 3'b101);
        mode = 2'd1;
        chk_rgb("sw_hold_8_15", 8, 15, 3'b101);
        chk_rgb("sw_new_0_0", 0, 0, 3'b010);
        chk_rgb("sw_new_8_0", 8, 0, 3'b101);

        // Checker with white/black
        fg_color = 3'b111;
        bg_color = 3'b000;
        chk_rgb("ck_7_8",   7, 8,   3'b111);
        chk_rgb("ck_8_8",   8, 8,   3'b000);
        chk_rgb("ck_32_8",  32, 8,  3'b111);
        chk_rgb("ck_35_16", 35, 16, 3'b000);
        mode = 2'd2;

        // Framebuffer mode
        chk_rgb("fb_24_0",  24, 0,  3'b011);
        chk_rgb("fb_0_8",   0, 8,   3'b101);
        at_pixel(40, 8);  check_eq("fb_addr_hblank", {27'd0, mem_addr}, 32'd9);
        chk_rgb("fb_16_16", 16, 16, 3'b100);
        chk_rgb("fb_35_19", 35, 19, 3'b110);
        at_pixel(10, 22); check_eq("fb_addr_vblank", {27'd0, mem_addr}, 32'd14);
        mode     = 2'd3;
        fg_color = 3'b101;
        bg_color = 3'b010;

        // Border mode, including the partial last column and row
        chk_rgb("bd_16_0",  16, 0,  3'b101);
        chk_rgb("bd_0_8",   0, 8,   3'b101);
        chk_rgb("bd_16_8",  16, 8,  3'b010);
        chk_rgb("bd_32_8",  32, 8,  3'b101);
        chk_rgb("bd_16_16", 16, 16, 3'b101);

        // One-clock reset in the middle of a frame
        chk_rgb("pre_rst", 0, 10, 3'b101);
        reset = 1'b1;
        @(negedge clk);
        check_eq("mid_rst_rgb",   {29'd0, rgb}, 32'd0);
        check_eq("mid_rst_hsync", {31'd0, hSync}, 32'd1);
        check_eq("mid_rst_vsync", {31'd0, vSync}, 32'd1);
        check_eq("mid_rst_addr",  {27'd0, mem_addr}, 32'd0);
        reset = 1'b0;
        n     = 0;
        fs_n  = 0;
        vs_ok = 1'b1;
        while (hSync !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
            if (frame_start && fs_n == 0) fs_n = n;
            if (vSync !== 1'b1) vs_ok = 1'b0;
        end
        check_eq("rst_hs_fall_clk", n, 32'd80);
        check_eq("rst_fs_clk", fs_n, 32'd4);
        check_eq("rst_no_vs", {31'd0, vs_ok}, 32'd1);
        chk_rgb("post_rst_bd", 16, 8, 3'b010);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_superpix_renderer.md
# vga_superpix_renderer

Parametrised VGA raster engine that replaces the fixed switch-colour test top. It generates its own pixel-clock enable, horizontal/vertical timing and superpixel coordinates. It drives registered RGB plus hSync/vSync pins in one of four render modes, including a read-only framebuffer port with one superpixel per memory word. It sits between the superpixel framebuffer RAM and the VGA connector.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync widths (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync widths (lines)
- CLK_DIV, 2, clk cycles per pixel; must be ≥2
- SP_SHIFT, 5, superpixel edge = 2^SP_SHIFT pixels (32)
- COLOR_W, 1, bits per colour channel
- ADDR_W, 9, framebuffer address width
- SYNC_POL, 0, active level of hSync/vSync
---
- clk  in  1  system clock (50 MHz)
- reset  in  1  synchronous, active-high
- mode  in  2  render mode; 0 solid, 1 checker, 2 framebuffer, 3 border
- fg_color  in  3*COLOR_W  foreground {R,G,B}
- bg_color  in  3*COLOR_W  background {R,G,B}
- mem_addr  out  ADDR_W  framebuffer read address
- mem_data  in  3*COLOR_W  framebuffer word; valid one clk after mem_addr changes
- R, G, B  out  COLOR_W each  registered colour
- hSync, vSync  out  1  registered syncs
- frame_start  out  1  one-clk pulse with the first pixel of each frame

## Operation
- Divider: div counts 0..CLK_DIV-1. pix_en = (div == CLK_DIV-1). All pipeline registers advance only on pix_en.
- Stage A, counters:
  - h_cnt counts 0..H_TOT-1, where H_TOT = sum of the four H params.
  - At H_TOT-1, h_cnt wraps to 0 and v_cnt increments.
  - v_cnt wraps from V_TOT-1 to 0.
- Stage A, decode:
  - active = h_cnt < H_ACTIVE && v_cnt < V_ACTIVE.
  - hs = h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC). vs is defined the same way on v_cnt.
- Stage B (registered):
  - xsp = h_cnt >> SP_SHIFT, ysp = v_cnt >> SP_SHIFT.
  - SP_COLS = ceil(H_ACTIVE / 2^SP_SHIFT), which gives 20; SP_ROWS gives 15.
  - mem_addr = ysp*SP_COLS + xsp, truncated to ADDR_W. It updates only while active; during blanking it holds.
  - active, hs and vs are delayed alongside.
- Stage C (registered):
  - If inactive, colour = 0. Otherwise colour is set by mode_q:
    - mode 0: fg_color.
    - mode 1: fg if xsp[0]^ysp[0], else bg.
    - mode 2: mem_data.
    - mode 3: fg if xsp==0, ysp==0, xsp==SP_COLS-1 or ysp==SP_ROWS-1, else bg.
  - hSync = hs ? SYNC_POL : ~SYNC_POL. vSync follows the same rule.
- mode_q latches `mode` only on the pix_en where stage A is at (0,0). A mid-frame mode change takes effect at the next frame; there is no tearing.
- Partial superpixels: when H_ACTIVE or V_ACTIVE is not a multiple of 2^SP_SHIFT, the last column or row is narrower and is rendered normally.

## Timing
- Reset values:
  - div, h_cnt, v_cnt, mem_addr, mode_q = 0.
  - R, G, B = 0.
  - hSync = vSync = ~SYNC_POL.
  - frame_start = 0.
  - Pipeline valid/active flags = 0.
- After reset, stage A sits at (0,0), so mode_q latches on the first pix_en.
- Latency: pixel (h,v) is decoded at stage A and appears on R/G/B/hSync/vSync 2 pix_en ticks later. Colour and syncs stay mutually aligned.
- Memory: mem_addr is stable for CLK_DIV clks. mem_data is sampled at the next pix_en, which is ≥1 clk later.
- frame_start is high for exactly one clk: the clk edge on which stage C outputs pixel (0,0).
- Reset asserted mid-frame: all state returns to reset values on the next edge. Counting restarts at (0,0) on deassertion, with no partial sync pulse.
- Sizes at default parameters: H_TOT = 800, V_TOT = 525, frame = 420000 pix_en = 840000 clk.

## Test plan
- Reset, then mode 0, fg = 3'b101, run 1 frame:
  - active pixels are R=1, G=0, B=1; blanking is 0.
  - hSync low for 96 pixels starting at output pixel h=656.
  - vSync low for lines 490–491.
  - frame_start pulses every 840000 clk.
- Mode 1, fg = 3'b111, bg = 3'b000:
  - pixel (31,0) = 000, pixel (32,0) = 111, pixel (32,32) = 000.
- Mode 2, RAM model with word = addr[2:0]:
  - pixel (32,32) reads addr 21 and outputs 3'b101.
  - pixel (639,479) reads addr 299 and outputs 3'b011.
  - mem_addr holds during blanking.
- Mode 3:
  - superpixels (0,5), (19,5) and (5,14) are fg; (5,5) is bg.
- Switch mode 0→1 at line 200:
  - remainder of the frame stays solid; checker starts at the pixel (0,0) flagged by frame_start.
- Assert reset for 1 clk at line 300:
  - next clk: RGB = 0, syncs inactive, mem_addr = 0.
  - first hSync falls 2+656 pix_en after deassertion.
